// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and types for mux_scan_sequencer.
//   NUM_CH / SEL_W   : channel count of the companion 4:1 mux and its select width
//   CNT_W            : dwell counter width (DWELL legal range 1..255)
//   state_e          : scan FSM encoding (ST_IDLE=0, ST_SCAN=1)
//   dwell_load()     : counter reload value for a given dwell time
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // The counter is loaded with DWELL-1 so the capture lands DWELL edges after the load.
    function automatic logic [CNT_W-1:0] dwell_load(input int unsigned dwell);
        return CNT_W'(dwell - 1);
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// dwell_timer: loadable down-counter that paces each channel of a scan.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one, saturating at zero
//   zero_c       : counter currently reads zero (combinational from the register)
module dwell_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux select through channels 0..3, holds each
// for DWELL cycles and captures the mux output into a four-entry bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a scan (only looked at while idle)
//   cont       : keep scanning; looked at on each channel-3 capture
//   Y          : mux output, combinational from S
//   S          : mux select
//   Q0..Q3     : captured value per channel
//   busy       : scan in progress
//   done       : one-cycle pulse after channel 3 is captured
//   chg        : per-channel "value changed at last capture" flags
//                (present only when MUX_SCAN_CHANGE_DET_EN is defined)
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic [WIDTH-1:0]  Y,
    output logic [SEL_W-1:0]  S,
    output logic [WIDTH-1:0]  Q0,
    output logic [WIDTH-1:0]  Q1,
    output logic [WIDTH-1:0]  Q2,
    output logic [WIDTH-1:0]  Q3,
    output logic              busy,
    output logic              done
`ifdef MUX_SCAN_CHANGE_DET_EN
    ,
    output logic [NUM_CH-1:0] chg
`endif
);

    localparam logic [CNT_W-1:0] DWELL_LD = dwell_load(DWELL);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   cap_q [NUM_CH];
    logic [WIDTH-1:0]   cap_d [NUM_CH];
`ifdef MUX_SCAN_CHANGE_DET_EN
    logic [NUM_CH-1:0]  chg_q, chg_d;
`endif

    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero_c;

    dwell_timer u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (DWELL_LD),
        .dec_i      (tmr_dec),
        .zero_c     (tmr_zero_c)
    );

    // Scan FSM next-state, select stepping and capture bank update.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cap_d    = cap_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
`ifdef MUX_SCAN_CHANGE_DET_EN
        chg_d    = chg_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    s_d      = '0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                end
            end

            ST_SCAN: begin
                if (!tmr_zero_c) begin
                    tmr_dec = 1'b1;
                end else begin
                    cap_d[s_q] = Y;
`ifdef MUX_SCAN_CHANGE_DET_EN
                    chg_d[s_q] = (Y != cap_q[s_q]);
`endif
                    if (s_q != LAST_SEL) begin
                        s_d      = s_q + SEL_W'(1);
                        tmr_load = 1'b1;
                    end else begin
                        // Last channel: wrap the select explicitly, then either
                        // roll straight into another scan or drop back to idle.
                        done_d = 1'b1;
                        s_d    = '0;
                        if (cont) begin
                            tmr_load = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cap_q[i] <= '0;
            end
`ifdef MUX_SCAN_CHANGE_DET_EN
            chg_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cap_q[i] <= cap_d[i];
            end
`ifdef MUX_SCAN_CHANGE_DET_EN
            chg_q   <= chg_d;
`endif
        end
    end

    assign S    = s_q;
    assign Q0   = cap_q[0];
    assign Q1   = cap_q[1];
    assign Q2   = cap_q[2];
    assign Q3   = cap_q[3];
    assign busy = busy_q;
    assign done = done_q;
`ifdef MUX_SCAN_CHANGE_DET_EN
    assign chg  = chg_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: two sequencers (DWELL=4 and DWELL=1) share start/cont
// and a set of mux inputs; each drives its own 4:1 mux. A timeline model
// (elapsed edges since scan start) predicts every output every cycle.
module tb_mux_scan_sequencer;

    localparam int DW0 = 4;
    localparam int DW1 = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont  = 1'b0;
    logic       chk_en = 1'b0;
    logic [7:0] a [4];

    logic [1:0] s_o    [2];
    logic [7:0] y      [2];
    logic [7:0] q_o    [2][4];
    logic       busy_o [2];
    logic       done_o [2];
    logic [3:0] chg_o  [2];

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt0 = 0;

    // Behavioural model state
    int         m_t    [2];
    logic       m_busy [2];
    logic       m_done [2];
    logic [1:0] m_s    [2];
    logic [7:0] m_q    [2][4];
    logic [3:0] m_chg  [2];

    always #5 clk = ~clk;

    assign y[0] = a[s_o[0]];
    assign y[1] = a[s_o[1]];

    mux_scan_sequencer #(.WIDTH(8), .DWELL(DW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .Y(y[0]), .S(s_o[0]),
        .Q0(q_o[0][0]), .Q1(q_o[0][1]), .Q2(q_o[0][2]), .Q3(q_o[0][3]),
        .busy(busy_o[0]), .done(done_o[0])
`ifdef MUX_SCAN_CHANGE_DET_EN
        , .chg(chg_o[0])
`endif
    );

    mux_scan_sequencer #(.WIDTH(8), .DWELL(DW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .Y(y[1]), .S(s_o[1]),
        .Q0(q_o[1][0]), .Q1(q_o[1][1]), .Q2(q_o[1][2]), .Q3(q_o[1][3]),
        .busy(busy_o[1]), .done(done_o[1])
`ifdef MUX_SCAN_CHANGE_DET_EN
        , .chg(chg_o[1])
`endif
    );

`ifndef MUX_SCAN_CHANGE_DET_EN
    assign chg_o[0] = 4'b0;
    assign chg_o[1] = 4'b0;
`endif

    function automatic int dw_of(input int i);
        return (i == 0) ? DW0 : DW1;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_t[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_s[i] = 2'd0; m_chg[i] = 4'd0;
        for (int k = 0; k < 4; k++) m_q[i][k] = 8'd0;
    endtask

    // A scan is a timeline of 4*DWELL edges; channel n is captured when
    // DWELL*(n+1) edges have elapsed since the start edge.
    task automatic model_step(input int i);
        int dw, n;
        dw = dw_of(i);
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
            if (start) begin
                m_busy[i] = 1'b1;
                m_t[i]    = 0;
            end
        end else begin
            m_t[i]++;
            if (m_t[i] % dw == 0) begin
                n = m_t[i] / dw - 1;
                m_chg[i][n] = (a[n] != m_q[i][n]);
                m_q[i][n]   = a[n];
                if (n == 3) begin
                    m_done[i] = 1'b1;
                    m_t[i]    = 0;
                    if (!cont) m_busy[i] = 1'b0;
                end
            end
        end
        m_s[i] = 2'(m_t[i] / dw);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) model_reset(i);
                else        model_step(i);
            end
        end
    end

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check("S", i, 32'(s_o[i]), 32'(m_s[i]));
            check("busy", i, 32'(busy_o[i]), 32'(m_busy[i]));
            check("done", i, 32'(done_o[i]), 32'(m_done[i]));
            for (int k = 0; k < 4; k++)
                check("Q", i * 10 + k, 32'(q_o[i][k]), 32'(m_q[i][k]));
`ifdef MUX_SCAN_CHANGE_DET_EN
            check("chg", i, 32'(chg_o[i]), 32'(m_chg[i]));
`endif
        end
    endtask

    // Single compare process: outputs are sampled mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                compare_all();
                if (done_o[0]) done_cnt0++;
            end
        end
    end

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            check({name, "_S"}, i, 32'(s_o[i]), 32'd0);
            check({name, "_busy"}, i, 32'(busy_o[i]), 32'd0);
            check({name, "_done"}, i, 32'(done_o[i]), 32'd0);
            for (int k = 0; k < 4; k++)
                check({name, "_Q"}, i * 10 + k, 32'(q_o[i][k]), 32'd0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        a[0] = 8'h01; a[1] = 8'h03; a[2] = 8'h07; a[3] = 8'h0F;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Basic scan with an ignored start at E0+5; sitting just after E0 here.
        pulse_start();
        repeat (4) @(negedge clk);                       // after E0+4
        check("dw1_done", 1, 32'(done_o[1]), 32'd1);
        check("dw1_busy", 1, 32'(busy_o[1]), 32'd0);
        check("dw1_Q0", 1, 32'(q_o[1][0]), 32'h01);
        check("dw1_Q1", 1, 32'(q_o[1][1]), 32'h03);
        check("dw1_Q2", 1, 32'(q_o[1][2]), 32'h07);
        check("dw1_Q3", 1, 32'(q_o[1][3]), 32'h0F);
        start = 1'b1;
        @(negedge clk); start = 1'b0;                     // after E0+5
        repeat (9) @(negedge clk);                       // after E0+14
        check("basic_S_ch3", 0, 32'(s_o[0]), 32'd3);
        check("basic_Q3_pending", 0, 32'(q_o[0][3]), 32'd0);
        check("basic_Q2_early", 0, 32'(q_o[0][2]), 32'h07);
        @(negedge clk);                                  // after E0+15
        check("basic_done_early", 0, 32'(done_o[0]), 32'd0);
        check("basic_busy_held", 0, 32'(busy_o[0]), 32'd1);
        @(negedge clk);                                  // after E0+16
        check("basic_done", 0, 32'(done_o[0]), 32'd1);
        check("basic_busy_fall", 0, 32'(busy_o[0]), 32'd0);
        check("basic_S_wrap", 0, 32'(s_o[0]), 32'd0);
        check("basic_Q0", 0, 32'(q_o[0][0]), 32'h01);
        check("basic_Q1", 0, 32'(q_o[0][1]), 32'h03);
        check("basic_Q2", 0, 32'(q_o[0][2]), 32'h07);
        check("basic_Q3", 0, 32'(q_o[0][3]), 32'h0F);
`ifdef MUX_SCAN_CHANGE_DET_EN
        check("chg_scan1", 0, 32'(chg_o[0]), 32'hF);
`endif
        @(negedge clk);                                  // after E0+17
        check("basic_done_once", 0, 32'(done_o[0]), 32'd0);
        repeat (3) @(negedge clk);

`ifdef MUX_SCAN_CHANGE_DET_EN
        a[1] = 8'hAA;
        pulse_start();
        repeat (16) @(negedge clk);
        check("chg_scan2", 0, 32'(chg_o[0]), 32'h2);
        check("chg_scan2_Q1", 0, 32'(q_o[0][1]), 32'hAA);
        repeat (3) @(negedge clk);
`endif

        // Continuous mode: three scans, A2 changes during scan 2.
        done_cnt0 = 0;
        cont = 1'b1;
        pulse_start();                                   // after E0
        repeat (20) @(negedge clk); a[2] = 8'h55;        // after E0+20
        repeat (16) @(negedge clk); cont = 1'b0;         // after E0+36
        repeat (12) @(negedge clk);                      // after E0+48
        check("cont_done3", 0, 32'(done_o[0]), 32'd1);
        check("cont_busy_fall", 0, 32'(busy_o[0]), 32'd0);
        repeat (4) @(negedge clk);
        check("cont_pulses", 0, 32'(done_cnt0), 32'd3);
        check("cont_Q2", 0, 32'(q_o[0][2]), 32'h55);

        // Reset mid-scan at E0+9, between clock edges.
        pulse_start();                                   // after E0
        repeat (8) @(negedge clk);
        @(posedge clk);                                  // E0+9
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk); rst_n = 1'b1;
        pulse_start();
        repeat (16) @(negedge clk);
        check("rst_rescan_done", 0, 32'(done_o[0]), 32'd1);
        check("rst_rescan_Q0", 0, 32'(q_o[0][0]), 32'h01);
        check("rst_rescan_Q2", 0, 32'(q_o[0][2]), 32'h55);
        check("rst_rescan_Q3", 0, 32'(q_o[0][3]), 32'h0F);
        repeat (3) @(negedge clk);

        // Randomised traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            cont  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) a[$urandom_range(0, 3)] = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_rst_busy", 0, 32'(busy_o[0]), 32'd0);
                check("rand_rst_S", 1, 32'(s_o[1]), 32'd0);
                #1 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        cont  = 1'b0;
        repeat (20) @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
